// File: rtl/shot_seq.sv
// nshot experiment sequencer with per-channel accumulation-buffer write pointers.
// Optional shot timestamping is enabled by defining SHOT_TIMESTAMP_EN.
module shot_seq #(
  parameter int unsigned NPROC        = 4,
  parameter int unsigned SHOTWIDTH    = 32,
  parameter int unsigned ACCADDRWIDTH = 10,
  parameter int unsigned DELAYWIDTH   = 24,
  parameter int unsigned TOWIDTH      = 32,
  parameter int unsigned TSWIDTH      = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          stb_start_i,
  input  logic                          stb_abort_i,
  input  logic [SHOTWIDTH-1:0]          nshot_i,
  input  logic [DELAYWIDTH-1:0]         rest_delay_i,
  input  logic [TOWIDTH-1:0]            timeout_i,
  input  logic [NPROC-1:0]              proc_en_i,
  input  logic [NPROC-1:0]              procdone_i,
  input  logic [NPROC-1:0]              nobusy_i,
  input  logic [NPROC-1:0]              accvalid_i,
  input  logic                          resetacc_i,
  input  logic                          acc_wrap_i,
  output logic [NPROC-1:0]              proccorereset_o,
  output logic                          busy_o,
  output logic                          lastshotdone_o,
  output logic [SHOTWIDTH-1:0]          shotcnt_o,
  output logic                          timeout_err_o,
`ifdef SHOT_TIMESTAMP_EN
  output logic [TSWIDTH-1:0]            shot_tstamp_o,
  output logic                          stb_shot_tstamp_o,
`endif
  output logic [NPROC*ACCADDRWIDTH-1:0] addr_accbuf_o,
  output logic [NPROC-1:0]              we_accbuf_o,
  output logic [NPROC-1:0]              acc_full_o
);

  typedef enum logic [2:0] {
    StIdle, StStart, StProcRun, StDrain, StMoreShot, StRest, StDone
  } state_e;

  localparam logic [ACCADDRWIDTH-1:0] AddrMax = '1;

  state_e                  state_q, state_d;
  logic [SHOTWIDTH-1:0]    nshot_q, nshot_d, shotcnt_q, shotcnt_d, nshot_eff;
  logic [DELAYWIDTH-1:0]   rest_delay_q, rest_delay_d, rest_cnt_q, rest_cnt_d;
  logic [TOWIDTH-1:0]      timeout_q, timeout_d, to_cnt_q, to_cnt_d;
  logic [NPROC-1:0]        en_q, en_d, proccorereset_q, proccorereset_d;
  logic                    timeout_err_q, timeout_err_d, lastshotdone_q, lastshotdone_d;
  logic                    all_done, all_idle, timeout_hit, run_d;

  assign all_done    = &(procdone_i | ~en_q);
  assign all_idle    = &(nobusy_i | ~en_q);
  assign nshot_eff   = (nshot_q == '0) ? SHOTWIDTH'(1) : nshot_q;
  assign timeout_hit = (timeout_q != '0) && (to_cnt_q == timeout_q - TOWIDTH'(1));

  always_comb begin
    state_d       = state_q;
    nshot_d       = nshot_q;
    rest_delay_d  = rest_delay_q;
    timeout_d     = timeout_q;
    en_d          = en_q;
    shotcnt_d     = shotcnt_q;
    rest_cnt_d    = rest_cnt_q;
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      StIdle: begin
        if (stb_start_i) begin
          nshot_d       = nshot_i;
          rest_delay_d  = rest_delay_i;
          timeout_d     = timeout_i;
          en_d          = proc_en_i;
          shotcnt_d     = '0;
          timeout_err_d = 1'b0;
          state_d       = StStart;
        end
      end
      StStart: state_d = StProcRun;
      StProcRun: begin
        if (all_done) begin
          state_d = StDrain;
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          state_d       = StDone;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TOWIDTH'(1);
        end
      end
      StDrain: begin
        if (all_idle) begin
          if (shotcnt_q != '1) shotcnt_d = shotcnt_q + SHOTWIDTH'(1);
          state_d = StMoreShot;
        end
      end
      StMoreShot: begin
        if (shotcnt_q >= nshot_eff) begin
          state_d = StDone;
        end else if (rest_delay_q == '0) begin
          state_d = StStart;
        end else begin
          rest_cnt_d = '0;
          state_d    = StRest;
        end
      end
      StRest: begin
        if (rest_cnt_q == rest_delay_q - DELAYWIDTH'(1)) state_d = StStart;
        else rest_cnt_d = rest_cnt_q + DELAYWIDTH'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort drops the run without touching the shot count or error flag.
    if (state_q != StIdle && stb_abort_i) begin
      state_d       = StIdle;
      shotcnt_d     = shotcnt_q;
      timeout_err_d = timeout_err_q;
    end
    if (state_d == StStart) to_cnt_d = '0;
    run_d           = (state_d == StStart) || (state_d == StProcRun) || (state_d == StDrain);
    proccorereset_d = ~({NPROC{run_d}} & en_d);
    lastshotdone_d  = (state_d == StDone) && !timeout_err_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= StIdle;
      nshot_q         <= '0;
      rest_delay_q    <= '0;
      timeout_q       <= '0;
      en_q            <= '0;
      shotcnt_q       <= '0;
      rest_cnt_q      <= '0;
      to_cnt_q        <= '0;
      timeout_err_q   <= 1'b0;
      proccorereset_q <= '1;
      lastshotdone_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      nshot_q         <= nshot_d;
      rest_delay_q    <= rest_delay_d;
      timeout_q       <= timeout_d;
      en_q            <= en_d;
      shotcnt_q       <= shotcnt_d;
      rest_cnt_q      <= rest_cnt_d;
      to_cnt_q        <= to_cnt_d;
      timeout_err_q   <= timeout_err_d;
      proccorereset_q <= proccorereset_d;
      lastshotdone_q  <= lastshotdone_d;
    end
  end

  assign proccorereset_o = proccorereset_q;
  assign busy_o          = (state_q != StIdle);
  assign lastshotdone_o  = lastshotdone_q;
  assign shotcnt_o       = shotcnt_q;
  assign timeout_err_o   = timeout_err_q;

  // Accumulation write pointers; lock_q marks a channel parked at the last address.
  logic [NPROC-1:0][ACCADDRWIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [NPROC-1:0]                   we_q, we_d, full_q, full_d, lock_q, lock_d;

  always_comb begin
    ptr_d  = ptr_q;
    addr_d = addr_q;
    full_d = full_q;
    lock_d = lock_q;
    we_d   = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (resetacc_i) begin
        ptr_d[i]  = '0;
        addr_d[i] = '0;
        full_d[i] = 1'b0;
        lock_d[i] = 1'b0;
      end else if (accvalid_i[i] && (acc_wrap_i || !lock_q[i])) begin
        we_d[i]   = 1'b1;
        addr_d[i] = ptr_q[i];
        if (ptr_q[i] == AddrMax) begin
          full_d[i] = 1'b1;
          lock_d[i] = !acc_wrap_i;
          ptr_d[i]  = acc_wrap_i ? '0 : AddrMax;
        end else begin
          ptr_d[i] = ptr_q[i] + ACCADDRWIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q  <= '0;
      addr_q <= '0;
      we_q   <= '0;
      full_q <= '0;
      lock_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      full_q <= full_d;
      lock_q <= lock_d;
    end
  end

  assign addr_accbuf_o = addr_q;
  assign we_accbuf_o   = we_q;
  assign acc_full_o    = full_q;

`ifdef SHOT_TIMESTAMP_EN
  logic [TSWIDTH-1:0] ts_cnt_q, shot_tstamp_q;
  logic               stb_ts_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_cnt_q      <= '0;
      shot_tstamp_q <= '0;
      stb_ts_q      <= 1'b0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TSWIDTH'(1);
      stb_ts_q <= (state_d == StStart);
      if (state_d == StStart) shot_tstamp_q <= ts_cnt_q;
    end
  end

  assign shot_tstamp_o     = shot_tstamp_q;
  assign stb_shot_tstamp_o = stb_ts_q;
`else
  logic [TSWIDTH-1:0] unused_tswidth;
  assign unused_tswidth = '0;
`endif

endmodule
